// File: rtl/alu_reg_pkg.sv
// Shared types and default sizes for the alu_reg_seq register/ALU sequencer.
package alu_reg_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int REG_CNT_DEF = 4;

    typedef enum logic [2:0] {
        OP_MOV = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_NOT = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_reg_file.sv
// REG_CNT x DATA_W register file: one write port, combinational reads for
// operand A, operand B and debug.
module alu_reg_file #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4,
    localparam int AW     = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [AW-1:0]     raddr_dbg,
    output logic [DATA_W-1:0] rdata_dbg
);

    logic [DATA_W-1:0] regs [REG_CNT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a   = regs[raddr_a];
    assign rdata_b   = regs[raddr_b];
    assign rdata_dbg = regs[raddr_dbg];

endmodule

// File: rtl/alu_reg_seq.sv
// Four-state (IDLE/READ/EXEC/WRITE) ALU sequencer over a small register file.
// Define ALU_REG_SEQ_FLAGS_EN to add the flag_c / flag_z outputs.
module alu_reg_seq
    import alu_reg_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_CNT = REG_CNT_DEF,
    localparam int AW     = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [AW-1:0]     req_src_a,
    input  logic [AW-1:0]     req_src_b,
    input  logic [AW-1:0]     req_dst,
    output logic              done,
    output logic [DATA_W-1:0] result,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`ifdef ALU_REG_SEQ_FLAGS_EN
    ,
    output logic              flag_c,
    output logic              flag_z
`endif
);

    state_e            state;
    op_e               op_q;
    logic [AW-1:0]     src_a_q, src_b_q, dst_q;
    logic [DATA_W-1:0] opa, opb, rd_a, rd_b;
    logic [DATA_W:0]   alu_w, alu_q;
    logic              we;

    assign req_ready = (state == ST_IDLE);
    assign we        = (state == ST_WRITE) && (op_q != OP_NOP);

    alu_reg_file #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (dst_q),
        .wdata     (alu_q[DATA_W-1:0]),
        .raddr_a   (src_a_q),
        .rdata_a   (rd_a),
        .raddr_b   (src_b_q),
        .rdata_b   (rd_b),
        .raddr_dbg (dbg_addr),
        .rdata_dbg (dbg_data)
    );

    // Bit DATA_W carries the ADD carry-out, or the SUB borrow (set when A < B).
    always_comb begin
        alu_w = '0;
        case (op_q)
            OP_MOV:  alu_w = {1'b0, opa};
            OP_ADD:  alu_w = {1'b0, opa} + {1'b0, opb};
            OP_SUB:  alu_w = {1'b0, opa} - {1'b0, opb};
            OP_AND:  alu_w = {1'b0, opa & opb};
            OP_OR:   alu_w = {1'b0, opa | opb};
            OP_XOR:  alu_w = {1'b0, opa ^ opb};
            OP_NOT:  alu_w = {1'b0, ~opa};
            default: alu_w = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_q    <= OP_NOP;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            opa     <= '0;
            opb     <= '0;
            alu_q   <= '0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (req_valid) begin
                    op_q    <= op_e'(req_op);
                    src_a_q <= req_src_a;
                    src_b_q <= req_src_b;
                    dst_q   <= req_dst;
                    state   <= ST_READ;
                end
                ST_READ: begin
                    opa   <= rd_a;
                    opb   <= rd_b;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    alu_q <= alu_w;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    done   <= 1'b1;
                    result <= alu_q[DATA_W-1:0];
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_REG_SEQ_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (we) begin
            flag_z <= (alu_q[DATA_W-1:0] == '0);
            if (op_q == OP_ADD || op_q == OP_SUB) flag_c <= alu_q[DATA_W];
        end
    end
`else
    logic unused_carry;
    assign unused_carry = alu_q[DATA_W];
`endif

endmodule

// File: tb/tb_alu_reg_seq.sv
// Self-checking bench for alu_reg_seq: directed scenarios plus random ops
// against an arithmetic reference model (flags checked when ALU_REG_SEQ_FLAGS_EN).
module tb_alu_reg_seq;

    localparam int DATA_W  = 8;
    localparam int REG_CNT = 4;
    localparam int AW      = 2;
    localparam int MOD     = 1 << DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_op = 3'd7;
    logic [AW-1:0]     req_src_a = '0, req_src_b = '0, req_dst = '0;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [AW-1:0]     dbg_addr = '0;
    logic [DATA_W-1:0] dbg_data;
`ifdef ALU_REG_SEQ_FLAGS_EN
    logic              flag_c, flag_z;
`endif

    alu_reg_seq #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src_a (req_src_a),
        .req_src_b (req_src_b),
        .req_dst   (req_dst),
        .done      (done),
        .result    (result),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
`ifdef ALU_REG_SEQ_FLAGS_EN
        ,
        .flag_c    (flag_c),
        .flag_z    (flag_z)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned mreg [REG_CNT];
    int unsigned m_result = 0;
    bit          m_fc = 0, m_fz = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
`ifdef ALU_REG_SEQ_FLAGS_EN
        chk({tag, "_flag_c"}, {31'd0, flag_c}, {31'd0, m_fc});
        chk({tag, "_flag_z"}, {31'd0, flag_z}, {31'd0, m_fz});
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < REG_CNT; i++) mreg[i] = 0;
        m_result = 0;
        m_fc = 0;
        m_fz = 0;
    endtask

    // Issue one op from an IDLE negedge; returns at the negedge where done is high.
    task automatic do_op(input string tag, input int op, input int sa, input int sb,
                         input int d, input bit keep);
        int unsigned a, b, full, res;
        bit c;
        a = mreg[sa];
        b = mreg[sb];
        c = m_fc;
        res = 0;
        case (op)
            0: res = a;
            1: begin full = a + b; res = full % MOD; c = (full >= MOD); end
            2: begin res = (a + MOD - b) % MOD; c = (a < b); end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = (MOD - 1) - a;
            default: res = 0;
        endcase
        chk({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_op    = op[2:0];
        req_src_a = AW'(sa);
        req_src_b = AW'(sb);
        req_dst   = AW'(d);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("%s_busy%0d_done", tag, k), {31'd0, done}, 32'd0);
            chk($sformatf("%s_busy%0d_ready", tag, k), {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        if (op != 7) begin
            mreg[d] = res;
            m_fz = (res == 0);
            m_fc = c;
        end
        m_result = res;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_result"}, {24'd0, result}, m_result);
        dbg_addr = AW'(d);
        #1;
        chk({tag, "_dbg_dst"}, {24'd0, dbg_data}, mreg[d]);
        chk_flags(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        for (int i = 0; i < REG_CNT; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk($sformatf("rst_reg%0d", i), {24'd0, dbg_data}, 32'd0);
        end
        chk_flags("rst");

        // ADD of zero registers
        do_op("add_zero", 1, 0, 0, 1, 0);
        chk("add_zero_const", {24'd0, result}, 32'h00);

        // Build r0=0x05, r1=0xFF from an all-zero file
        do_op("seed_not", 6, 0, 0, 1, 0);
        do_op("seed_fe", 1, 1, 1, 2, 0);
        do_op("seed_01", 6, 2, 2, 2, 0);
        do_op("seed_02", 1, 2, 2, 3, 0);
        do_op("seed_04", 1, 3, 3, 3, 0);
        do_op("seed_05", 1, 3, 2, 0, 0);
        do_op("add_carry", 1, 0, 1, 2, 0);
        chk("add_carry_const", {24'd0, result}, 32'h04);

        do_op("sub_self", 2, 0, 0, 3, 0);
        chk("sub_self_const", {24'd0, result}, 32'h00);
        do_op("mk_one", 5, 0, 2, 2, 0);
        do_op("sub_borrow", 2, 3, 2, 3, 0);
        chk("sub_borrow_const", {24'd0, result}, 32'hFF);

        // NOP aimed at r0 (0x05) must not write and must zero result
        do_op("nop", 7, 1, 2, 0, 0);
        chk("nop_r0_kept", {24'd0, dbg_data}, 32'h05);

        for (int n = 0; n < 40; n++) begin
            do_op($sformatf("rnd%0d", n), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk($sformatf("rnd%0d_gap_done", n), {31'd0, done}, 32'd0);
            end
        end

        // req_valid held high: one accept per 4 cycles
        for (int n = 0; n < 8; n++)
            do_op($sformatf("b2b%0d", n), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_end_done", {31'd0, done}, 32'd0);
        chk("b2b_end_ready", {31'd0, req_ready}, 32'd1);

        // Reset during EXEC aborts the ADD
        req_op = 3'd1; req_src_a = 2'd0; req_src_b = 2'd1; req_dst = 2'd2;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("abort_rst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort_nodone%0d", k), {31'd0, done}, 32'd0);
        end
        dbg_addr = 2'd2;
        #1;
        chk("abort_r2", {24'd0, dbg_data}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk_flags("abort");
        do_op("post_abort", 6, 2, 2, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_reg_seq.md
ALU_REG_SEQ -- requirements
Module: alu_reg_seq

Interface
REQ-001 Parameter DATA_W, default 8, datapath and register width in bits.
REQ-002 Parameter REG_CNT, default 4, number of registers; power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  operation request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_op  input  3  opcode; see REQ-013.
REQ-008 req_src_a, req_src_b, req_dst  input  clog2(REG_CNT) each  source A, source B and destination register indices.
REQ-009 done  output  1  one-cycle pulse when an operation completes.
REQ-010 result  output  DATA_W  value produced by the completing operation; held until the next done.
REQ-011 dbg_addr  input  clog2(REG_CNT)  debug read index; dbg_data  output  DATA_W  combinational read of register dbg_addr.

Function
REQ-012 FSM states: IDLE, READ, EXEC, WRITE; IDLE->READ on req_valid && req_ready; READ->EXEC->WRITE unconditionally; WRITE->IDLE.
REQ-013 Opcodes: 000 MOV dst=A; 001 ADD A+B; 010 SUB A-B; 011 AND; 100 OR; 101 XOR; 110 NOT A; 111 NOP (no register write).
REQ-014 req_ready is 1 only in IDLE; request fields are captured on the accept edge and ignored while busy.
REQ-015 READ latches A and B from the register file; EXEC latches the ALU result; WRITE writes result to dst (except NOP) and pulses done.
REQ-016 Latency: done is high exactly 3 cycles after the accept edge; throughput 1 operation per 4 cycles.
REQ-017 Arithmetic is modulo 2^DATA_W; operands unsigned; no saturation.
REQ-018 src_a, src_b and dst may be equal; operands are those present before this operation's write.
REQ-019 An operation accepted after a done reads the value written by that done's operation.
REQ-020 NOP still passes through all states, pulses done, and leaves result = 0.
REQ-021 dbg_data reflects a write from the cycle after the WRITE edge.

Reset
REQ-022 rst forces IDLE, all registers to 0, done=0, result=0, and req_ready=1 after release, independent of clk.
REQ-023 rst asserted mid-operation aborts it: no register write, no done pulse.

Configuration
REQ-024 Macro ALU_REG_SEQ_FLAGS_EN defined: outputs flag_c and flag_z (1 bit each) exist; reset to 0.
REQ-025 With the macro: on WRITE, flag_z = (result == 0) for every non-NOP op; flag_c = carry-out for ADD and borrow for SUB, unchanged otherwise; NOP leaves both flags unchanged.
REQ-026 Without the macro: flag ports and flag logic are absent; all other behaviour is identical.

Structure
REQ-027 Package alu_reg_pkg holds the opcode enum, the FSM state enum and the default DATA_W/REG_CNT constants.
REQ-028 Sub-module alu_reg_file: REG_CNT x DATA_W, async reset, one write port, three combinational read ports (A, B, debug).

Verification
REQ-029 Reset then MOV: write r1 via sequence (preset r0=0); ADD r1=r0+r0 -> done after 3 cycles, result 0x00, dbg r1=0x00.
REQ-030 Seed r0=0x05 and r1=0xFF, then ADD r2=r0+r1 -> result 0x04; flag_c=1, flag_z=0 when flags are enabled.
REQ-031 SUB r3=r0-r0 -> result 0x00, flag_z=1, flag_c=0; SUB 0x00-0x01 -> 0xFF, flag_c=1.
REQ-032 req_valid held high continuously -> req_ready high only in IDLE, one accept every 4 cycles, no lost or duplicated ops.
REQ-033 rst pulsed during EXEC of ADD r2 -> no done pulse, r2 reads 0x00, req_ready=1 after release.
REQ-034 NOP with dst=r0 holding 0x05 -> done pulses, result 0x00, r0 still 0x05, flags unchanged.
